// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM states and the baud divisor helper.
// Reused by the parametrised transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // Oversampling tick divisor, integer floor.
    function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Restartable tick divider: one-cycle tick every DIV clocks, realigned by restart.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // A restart zeroes the count so the first tick lands DIV clocks later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CW'(DIV - 1)) && !restart;

endmodule

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-flop sync, oversampled 3-sample majority vote,
// optional parity, 1-2 stop bits, ready/valid holding register with overrun flag.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 rx_pin_in,
    input  logic                 rx_en_sig,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_LO  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic PAR_FLIP = 1'(PARITY == PAR_ODD);

    if (DIV < 2) begin : g_div_check
        $error("uart_rx_core: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_check
        $error("uart_rx_core: OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_fmt_check
        $error("uart_rx_core: unsupported frame format");
    end

    rx_state_t state, state_nxt;

    logic [1:0]           sync_q;
    logic                 line_prev;
    logic                 line;
    logic                 fall;
    logic                 restart;
    logic                 tick;
    logic [SW-1:0]        s_cnt;
    logic [SW-1:0]        tick_s;
    logic [1:0]           samp;
    logic                 decision;
    logic                 dec_tick;
    logic                 end_tick;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err_q;
    logic                 stop_err_q;
    logic                 deliver;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rstn    (rstn),
        .restart (restart),
        .tick    (tick)
    );

    assign line     = sync_q[1];
    assign fall     = line_prev && !line;
    assign tick_s   = (s_cnt == S_END) ? '0 : s_cnt + 1'b1;
    assign dec_tick = tick && (tick_s == S_HI);
    assign end_tick = tick && (tick_s == S_END);
    assign decision = (samp[0] & samp[1]) | (samp[0] & line) | (samp[1] & line);
    assign busy     = (state != ST_IDLE);

    // Synchroniser idles high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= 2'b11;
            line_prev <= 1'b1;
            state     <= ST_IDLE;
        end else begin
            sync_q    <= {sync_q[0], rx_pin_in};
            line_prev <= line;
            state     <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        deliver   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall && rx_en_sig) begin
                    state_nxt = ST_START;
                    restart   = 1'b1;
                end
            end
            ST_START: begin
                if (dec_tick && decision) begin
                    state_nxt = ST_IDLE;
                end else if (end_tick) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_tick && bit_cnt == 4'(DATA_BITS - 1)) begin
                    state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (end_tick) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Deliver mid-stop so the next start edge can be caught immediately.
                if (dec_tick && bit_cnt == 4'(STOP_BITS - 1)) begin
                    state_nxt = ST_IDLE;
                    deliver   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s_cnt      <= '0;
            samp       <= 2'b11;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            if (restart) begin
                s_cnt <= '0;
            end else if (tick) begin
                s_cnt <= tick_s;
            end

            if (tick && tick_s == S_LO) samp[0] <= line;
            if (tick && tick_s == S_MID) samp[1] <= line;

            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (end_tick && (state == ST_DATA || state == ST_STOP)) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state == ST_DATA && dec_tick) begin
                shift_reg <= {decision, shift_reg[DATA_BITS-1:1]};
            end

            if (restart) begin
                par_err_q  <= 1'b0;
                stop_err_q <= 1'b0;
            end else begin
                if (state == ST_PARITY && dec_tick) begin
                    par_err_q <= decision ^ (^shift_reg) ^ PAR_FLIP;
                end
                if (state == ST_STOP && dec_tick && !decision) begin
                    stop_err_q <= 1'b1;
                end
            end
        end
    end

    // A full holding register drops the new frame unless it is being read this cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= deliver && rx_valid && !rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data    <= shift_reg;
                parity_err <= par_err_q;
                frame_err  <= stop_err_q | ~decision;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
